uart_rx_8n1: RTL

Serial receive side of the UART: samples the asynchronous `rx` line, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop), and presents each byte on a parallel bus with a single-cycle valid strobe. Bit timing comes from an internal clock-divider counter at mid-bit, matching the transmit-side baud tick (divisor 434, half-bit 217 at 50 MHz / 115200 baud). The block sits between the board pin and the byte consumer (FIFO or command parser).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 37 +++
 rtl/uart_rx_8n1.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions used by the receive and transmit sides:
//   receiver state encoding, default bit-period divisor for 115200 baud
//   from a 50 MHz system clock, and the frame data width.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_115200 = 434;
    localparam int UART_DATA_BITS           = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
//   Two-flop synchronizer for a single asynchronous input.
//   Ports:
//     clk    in   destination clock
//     rst_n  in   asynchronous active-low reset; both flops load RST_VAL
//     d      in   asynchronous input
//     q      out  synchronized output (2-cycle latency)
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1
//   UART receiver for 8N1 frames (1 start, 8 data LSB first, 1 stop).
//   Bits are sampled at mid-bit by a counter restarted on every state
//   entry and every sample.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous active-low reset
//     rx         in   serial line, asynchronous, idle high
//     data       out  last correctly framed byte, held until the next one
//     valid      out  one-cycle pulse when data is updated
//     frame_err  out  one-cycle pulse when the stop bit is sampled low
//     busy       out  high whenever a frame is in progress
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    logic rxs;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (rx),
        .q     (rxs)
    );

    uart_state_e               state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                // Re-check the line at mid start bit; a short low glitch
                // returns to IDLE without producing anything.
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[UART_DATA_BITS-1:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (rxs) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here while the line stays low so a break condition
                // is not decoded as a stream of zero frames.
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    // Busy already in the detection cycle (IDLE with the line low).
    assign busy      = (state_q != ST_IDLE) || !rxs;

endmodule
